// File: rtl/crypto_req_arbiter_if.sv
// Bundles the requester-side and crypto-unit-side signals of the arbiter.
// Handshake rules, for every valid/ready pair in this bundle:
//   a transfer happens in a cycle where valid and ready are both high; the
//   sender keeps valid and payload stable until that cycle. Response pulses
//   (resp_valid, m_resp_valid) are single-cycle and carry no ready.
// The master modport is the arbiter's view; slave is the environment
// (requesters plus crypto unit).
interface crypto_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_rs1;
  logic [NUM_REQ*DATA_W-1:0] req_rs2;
  logic [NUM_REQ*2-1:0]      req_bs;
  logic [NUM_REQ-1:0]        req_flush;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_err;

  // crypto unit side
  logic                      m_req_valid;
  logic                      m_req_ready;
  logic [OP_W-1:0]           m_op;
  logic [DATA_W-1:0]         m_rs1;
  logic [DATA_W-1:0]         m_rs2;
  logic [1:0]                m_bs;
  logic                      m_resp_valid;
  logic [DATA_W-1:0]         m_resp_data;
  logic                      m_abort;

  // status / debug
  logic                      busy;
  logic [OWN_W-1:0]          owner;
  logic [1:0]                dbg_state;

  modport master (
    input  req_valid, req_op, req_rs1, req_rs2, req_bs, req_flush,
    input  m_req_ready, m_resp_valid, m_resp_data,
    output req_ready, resp_valid, resp_data, resp_err,
    output m_req_valid, m_op, m_rs1, m_rs2, m_bs, m_abort,
    output busy, owner, dbg_state
  );

  modport slave (
    output req_valid, req_op, req_rs1, req_rs2, req_bs, req_flush,
    output m_req_ready, m_resp_valid, m_resp_data,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  m_req_valid, m_op, m_rs1, m_rs2, m_bs, m_abort,
    input  busy, owner, dbg_state
  );
endinterface

// File: rtl/crypto_req_arbiter.sv
// Round-robin arbiter sharing one AES/SM4 crypto unit between NUM_REQ
// requesters. Latches the winner's operands, issues them on a single
// valid/ready channel, routes the result back to the owner, and handles
// owner flush and a response watchdog (timeout -> abort + error response).
module crypto_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  crypto_req_arbiter_if.master  bus
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [OWN_W-1:0] OWN_MAX  = OWN_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OWN_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   rs1_q, rs1_d;
  logic [DATA_W-1:0]   rs2_q, rs2_d;
  logic [1:0]          bs_q, bs_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;

  logic [OP_W-1:0]     op_a  [NUM_REQ];
  logic [DATA_W-1:0]   rs1_a [NUM_REQ];
  logic [DATA_W-1:0]   rs2_a [NUM_REQ];
  logic [1:0]          bs_a  [NUM_REQ];

  logic [NUM_REQ-1:0]  eligible;
  logic                grant_found;
  logic [OWN_W-1:0]    grant_idx;
  logic [OWN_W-1:0]    cand;
  logic [OWN_W-1:0]    next_ptr;
  logic                owner_flush;
  logic [NUM_REQ-1:0]  req_ready_c;
  logic                m_abort_c;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OWN_W-1:0] idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

  // Unpack the per-requester payload buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i]  = bus.req_op[i*OP_W +: OP_W];
      rs1_a[i] = bus.req_rs1[i*DATA_W +: DATA_W];
      rs2_a[i] = bus.req_rs2[i*DATA_W +: DATA_W];
      bs_a[i]  = bus.req_bs[i*2 +: 2];
    end
  end

  // Round-robin pick: first eligible index starting at rr_ptr, wrapping.
  always_comb begin
    eligible    = bus.req_valid & ~bus.req_flush;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = OWN_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // The requester after the owner gets first chance at the next grant.
  always_comb begin
    next_ptr    = (owner_q == OWN_MAX) ? '0 : owner_q + OWN_W'(1);
    owner_flush = bus.req_flush[owner_q];
  end

  // Next-state and combinational outputs of the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    timer_d      = timer_q;
    op_d         = op_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    bs_d         = bs_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_err_d   = 1'b0;
    req_ready_c  = '0;
    m_abort_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready_c = onehot(grant_idx);
          owner_d     = grant_idx;
          op_d        = op_a[grant_idx];
          rs1_d       = rs1_a[grant_idx];
          rs2_d       = rs2_a[grant_idx];
          bs_d        = bs_a[grant_idx];
          timer_d     = '0;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // A flush cancels the request even if the unit takes it this cycle.
        if (owner_flush) begin
          m_abort_c = 1'b1;
          rr_ptr_d  = next_ptr;
          state_d   = ST_IDLE;
        end else if (bus.m_req_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Priority: flush, then a real response, then the watchdog.
        if (owner_flush) begin
          m_abort_c = 1'b1;
          rr_ptr_d  = next_ptr;
          state_d   = ST_IDLE;
        end else if (bus.m_resp_valid) begin
          resp_valid_d = onehot(owner_q);
          resp_data_d  = bus.m_resp_data;
          resp_err_d   = 1'b0;
          rr_ptr_d     = next_ptr;
          state_d      = ST_IDLE;
        end else if (timer_q == TMR_LAST) begin
          m_abort_c    = 1'b1;
          resp_valid_d = onehot(owner_q);
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          rr_ptr_d     = next_ptr;
          state_d      = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched payload and registered response; reset drops everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      timer_q      <= '0;
      op_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      bs_q         <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      timer_q      <= timer_d;
      op_q         <= op_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      bs_q         <= bs_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.m_req_valid = (state_q == ST_ISSUE);
  assign bus.m_op        = op_q;
  assign bus.m_rs1       = rs1_q;
  assign bus.m_rs2       = rs2_q;
  assign bus.m_bs        = bs_q;
  assign bus.m_abort     = m_abort_c;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.owner       = owner_q;
  assign bus.dbg_state   = state_q;

  // At most one requester is accepted per cycle.
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.req_ready));

  // Abort only ever comes out of an active transaction.
  a_abort_not_idle: assert property (@(posedge clk) disable iff (rst)
    bus.m_abort |-> (state_q != ST_IDLE));

  // Request payload holds while the unit is stalling us.
  a_payload_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_ISSUE && !bus.m_req_ready && !owner_flush)
      |=> $stable({bus.m_op, bus.m_rs1, bus.m_rs2, bus.m_bs}));
endmodule
